rs232_rx: RTL and testbench

Serial-line receiver feeding the command-decode stage: converts the asynchronous 8N1 RS-232 input into parallel bytes on `RS_DATAOUT`, flagged by a one-cycle `RS_DONE` strobe. The downstream command FSM consumes `RS_DATAOUT` in the cycle `RS_DONE` is high. The block provides:
- input synchronisation,
- start-bit glitch rejection,
- mid-bit sampling,
- framing-error reporting.

---
 rtl/rs232_rx_if.sv | 25 ++
 rtl/rs232_rx.sv | 151 +++++++++++++++
 tb/tb_rs232_rx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_rx_if.sv
// Serial-receiver bundle: the line input and the byte/strobe/status outputs.
// The receiver takes the slave side; the consumer (or line driver) takes the master side.
interface rs232_rx_if;
    logic       RX;
    logic [7:0] RS_DATAOUT;
    logic       RS_DONE;
    logic       RS_FERR;
    logic       RS_BUSY;

    modport slave (
        input  RX,
        output RS_DATAOUT,
        output RS_DONE,
        output RS_FERR,
        output RS_BUSY
    );

    modport master (
        output RX,
        input  RS_DATAOUT,
        input  RS_DONE,
        input  RS_FERR,
        input  RS_BUSY
    );
endinterface

// File: rtl/rs232_rx.sv
// 8N1 RS-232 receiver: synchronises RX, rejects start glitches, samples mid-bit,
// and presents each good byte with a one-cycle RS_DONE strobe (RS_FERR on a bad stop bit).
module rs232_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        CLK_50MHZ,
    input  logic        RST_N,
    rs232_rx_if.slave   bus
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sh;
    logic          half_tick;
    logic          bit_tick;

    logic          done_nxt;
    logic          ferr_nxt;
    logic          busy_nxt;
    logic [7:0]    data_q;
    logic          done_q;
    logic          ferr_q;
    logic          busy_q;

    // Synchroniser flops reset to the idle level so reset never looks like a start bit.
    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep this a true two-stage pipeline.
            rx_m <= bus.RX;
            rx_s <= rx_m;
        end
    end

    assign half_tick = (cnt == CNT_HALF);
    assign bit_tick  = (cnt == CNT_LAST);

    // FSM process 1: state register.
    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM process 2: next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_nxt = S_START;
            end
            S_START: begin
                if (half_tick) state_nxt = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_tick && (idx == 3'd7)) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (bit_tick) state_nxt = rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (rx_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bit timer restarts on every state change and between data bits.
    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
            idx <= 3'd0;
            sh  <= 8'h00;
        end else begin
            if (state_nxt != state) begin
                cnt <= '0;
            end else if ((state == S_DATA) && bit_tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if ((state == S_START) && (state_nxt == S_DATA)) begin
                idx <= 3'd0;
            end else if ((state == S_DATA) && bit_tick) begin
                idx <= idx + 3'd1;
            end

            // LSB arrives first, so shifting right leaves it in bit 0 after eight bits.
            if ((state == S_DATA) && bit_tick) begin
                sh <= {rx_s, sh[7:1]};
            end
        end
    end

    // FSM process 3: output decode, registered below so RX never reaches a port combinationally.
    always_comb begin
        done_nxt = 1'b0;
        ferr_nxt = 1'b0;
        busy_nxt = (state_nxt != S_IDLE);
        if ((state == S_STOP) && bit_tick) begin
            done_nxt = rx_s;
            ferr_nxt = !rx_s;
        end
    end

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            data_q <= 8'h00;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            done_q <= done_nxt;
            ferr_q <= ferr_nxt;
            busy_q <= busy_nxt;
            if (done_nxt) begin
                data_q <= sh;
            end
        end
    end

    assign bus.RS_DATAOUT = data_q;
    assign bus.RS_DONE    = done_q;
    assign bus.RS_FERR    = ferr_q;
    assign bus.RS_BUSY    = busy_q;

endmodule

// File: tb/tb_rs232_rx.sv
// Directed bench for rs232_rx: a frame-timing model predicts every output per cycle,
// and a single compare process checks two instances (16 and 434 clocks per bit) against it.
module tb_rs232_rx;

    localparam int N = 16384;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rs232_rx_if bus16 ();
    rs232_rx_if bus434 ();

    rs232_rx #(.CLKS_PER_BIT(16)) dut16 (
        .CLK_50MHZ (clk),
        .RST_N     (rst_n),
        .bus       (bus16)
    );

    rs232_rx dut434 (
        .CLK_50MHZ (clk),
        .RST_N     (rst_n),
        .bus       (bus434)
    );

    // Model: expected outputs indexed by the number of the last rising edge.
    bit         exp_busy [2][N];
    bit         exp_done [2][N];
    bit         exp_ferr [2][N];
    logic [7:0] exp_data [2][N];
    int         cpb [2] = '{16, 434};

    int         n_checks = 0;
    int         n_errs   = 0;
    bit         chk_on   = 1'b0;
    int         done_cnt [2];
    int         ferr_cnt [2];
    int         last_done_cyc [2];
    logic [7:0] last_done_data [2];
    int         done_q0 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_dut(input int d, input logic [7:0] data, input logic done,
                             input logic ferr, input logic busy);
        check($sformatf("dut%0d RS_DATAOUT", d), 32'(data), 32'(exp_data[d][cyc]));
        check($sformatf("dut%0d RS_DONE", d), 32'(done), 32'(exp_done[d][cyc]));
        check($sformatf("dut%0d RS_FERR", d), 32'(ferr), 32'(exp_ferr[d][cyc]));
        check($sformatf("dut%0d RS_BUSY", d), 32'(busy), 32'(exp_busy[d][cyc]));
        if (done === 1'b1) begin
            done_cnt[d]++;
            last_done_cyc[d]  = cyc;
            last_done_data[d] = data;
            if (d == 0) done_q0.push_back(cyc);
        end
        if (ferr === 1'b1) ferr_cnt[d]++;
    endtask

    // The single compare process, on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (chk_on && (cyc < N)) begin
            check_dut(0, bus16.RS_DATAOUT, bus16.RS_DONE, bus16.RS_FERR, bus16.RS_BUSY);
            check_dut(1, bus434.RS_DATAOUT, bus434.RS_DONE, bus434.RS_FERR, bus434.RS_BUSY);
        end
    end

    task automatic set_rx(input int d, input logic v);
        if (d == 0) bus16.RX = v;
        else        bus434.RX = v;
    endtask

    task automatic set_busy(input int d, input int lo, input int hi, input bit v);
        for (int c = lo; c < hi; c++) if (c >= 0 && c < N) exp_busy[d][c] = v;
    endtask

    // Drives the first nbits bit-times of a frame (start, 8 data LSB first, stop) and
    // schedules the outputs: edge 0 is the next rising edge, stop sample at 2+HALF+9*CPB.
    task automatic send_frame(input int d, input logic [7:0] b, input bit stop_val,
                              input int nbits, output int e0);
        int   half;
        int   se;
        logic v;
        half = cpb[d] / 2;
        e0   = cyc + 1;
        se   = e0 + 2 + half + 9 * cpb[d];
        if (nbits == 10 && stop_val) begin
            set_busy(d, e0 + 2, se, 1'b1);
            if (se < N) exp_done[d][se] = 1'b1;
            for (int c = se; c < N; c++) exp_data[d][c] = b;
        end else begin
            set_busy(d, e0 + 2, N, 1'b1);
            if (nbits == 10 && se < N) exp_ferr[d][se] = 1'b1;
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == 0)      v = 1'b0;
            else if (i <= 8) v = b[i-1];
            else             v = stop_val;
            set_rx(d, v);
            repeat (cpb[d]) @(negedge clk);
        end
    endtask

    task automatic glitch(input int d, input int len, output int e0);
        e0 = cyc + 1;
        set_busy(d, e0 + 2, e0 + 2 + cpb[d] / 2, 1'b1);
        set_rx(d, 1'b0);
        repeat (len) @(negedge clk);
        set_rx(d, 1'b1);
    endtask

    // Line returns high: two synchroniser edges plus one FSM edge before BUSY drops.
    task automatic break_release(input int d);
        set_busy(d, cyc + 3, N, 1'b0);
        set_rx(d, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int e0;
    int e1;
    int e2;
    int base_done;
    int base_ferr;
    int rc;

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) exp_data[d][c] = 8'h00;
            done_cnt[d]       = 0;
            ferr_cnt[d]       = 0;
            last_done_cyc[d]  = -1;
            last_done_data[d] = 8'h00;
        end
        bus16.RX  = 1'b1;
        bus434.RX = 1'b1;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1 chk_on = 1'b1;

        // Reset / idle
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle(1000);
        check("idle done count", 32'(done_cnt[0] + done_cnt[1]), 32'd0);
        check("idle ferr count", 32'(ferr_cnt[0] + ferr_cnt[1]), 32'd0);
        check("idle busy", 32'(bus16.RS_BUSY), 32'd0);

        // Single byte
        send_frame(0, 8'hA5, 1'b1, 10, e0);
        idle(20);
        check("model busy before edge 2", 32'(exp_busy[0][e0+1]), 32'd0);
        check("model busy at edge 2", 32'(exp_busy[0][e0+2]), 32'd1);
        check("model busy at edge 153", 32'(exp_busy[0][e0+153]), 32'd1);
        check("model busy at edge 154", 32'(exp_busy[0][e0+154]), 32'd0);
        check("model done at edge 154", 32'(exp_done[0][e0+154]), 32'd1);
        check("A5 done edge", 32'(last_done_cyc[0] - e0), 32'd154);
        check("A5 data", 32'(last_done_data[0]), 32'hA5);
        check("A5 done count", 32'(done_cnt[0]), 32'd1);
        check("A5 ferr count", 32'(ferr_cnt[0]), 32'd0);

        // Back-to-back
        send_frame(0, 8'h01, 1'b1, 10, e0);
        send_frame(0, 8'h02, 1'b1, 10, e1);
        send_frame(0, 8'h03, 1'b1, 10, e2);
        idle(20);
        check("b2b done count", 32'(done_cnt[0]), 32'd4);
        check("b2b first edge", 32'(done_q0[1] - e0), 32'd154);
        check("b2b spacing 1-2", 32'(done_q0[2] - done_q0[1]), 32'd160);
        check("b2b spacing 2-3", 32'(done_q0[3] - done_q0[2]), 32'd160);
        check("b2b last data", 32'(last_done_data[0]), 32'h03);

        send_frame(1, 8'h5A, 1'b1, 10, e0);
        idle(20);
        check("model 434 done at edge 4125", 32'(exp_done[1][e0+4125]), 32'd1);
        check("434 done edge", 32'(last_done_cyc[1] - e0), 32'd4125);
        check("434 data", 32'(last_done_data[1]), 32'h5A);

        // Glitch
        base_done = done_cnt[0];
        base_ferr = ferr_cnt[0];
        glitch(0, 5, e0);
        idle(30);
        check("model glitch busy edge 9", 32'(exp_busy[0][e0+9]), 32'd1);
        check("model glitch busy edge 10", 32'(exp_busy[0][e0+10]), 32'd0);
        check("glitch done count", 32'(done_cnt[0] - base_done), 32'd0);
        check("glitch ferr count", 32'(ferr_cnt[0] - base_ferr), 32'd0);
        check("glitch data kept", 32'(bus16.RS_DATAOUT), 32'h03);

        // Framing error and break
        send_frame(0, 8'h11, 1'b1, 10, e0);
        base_done = done_cnt[0];
        send_frame(0, 8'h00, 1'b0, 10, e1);
        idle(11 * 16);
        check("break busy held", 32'(bus16.RS_BUSY), 32'd1);
        break_release(0);
        idle(20);
        check("break ferr count", 32'(ferr_cnt[0] - base_ferr), 32'd1);
        check("break done count", 32'(done_cnt[0] - base_done), 32'd0);
        check("break data kept", 32'(bus16.RS_DATAOUT), 32'h11);
        send_frame(0, 8'h3C, 1'b1, 10, e2);
        idle(20);
        check("after break data", 32'(last_done_data[0]), 32'h3C);

        // Reset mid-frame during data bit 4 of 8'hFF
        base_done = done_cnt[0];
        base_ferr = ferr_cnt[0];
        send_frame(0, 8'hFF, 1'b1, 5, e0);
        set_rx(0, 1'b1);
        idle(8);
        @(posedge clk);
        #2 rst_n = 1'b0;
        rc = cyc;
        for (int d = 0; d < 2; d++) begin
            for (int c = rc; c < N; c++) begin
                exp_busy[d][c] = 1'b0;
                exp_done[d][c] = 1'b0;
                exp_ferr[d][c] = 1'b0;
                exp_data[d][c] = 8'h00;
            end
        end
        #1;
        check("reset busy immediate", 32'(bus16.RS_BUSY), 32'd0);
        check("reset data immediate", 32'(bus16.RS_DATAOUT), 32'h00);
        idle(3);
        rst_n = 1'b1;
        idle(40);
        check("aborted done count", 32'(done_cnt[0] - base_done), 32'd0);
        check("aborted ferr count", 32'(ferr_cnt[0] - base_ferr), 32'd0);
        send_frame(0, 8'hC3, 1'b1, 10, e1);
        idle(20);
        check("post-reset done edge", 32'(last_done_cyc[0] - e1), 32'd154);
        check("post-reset data", 32'(last_done_data[0]), 32'hC3);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
